// File: rtl/post_processing.sv
//-----------------------------------------------------------------------------
// post_processing
//
// Converts a Montgomery-domain value back to the normal domain:
//    out = X * 2^(-WIDTH) mod N
// This is the inverse of the pre-processing stage, which computes
// M * 2^WIDTH mod N. The block sits after the modular-exponentiation core and
// produces the final plaintext or ciphertext.
//
// Method: bit-serial Montgomery reduction. There is one halving step per
// clock for WIDTH clocks, followed by one conditional subtract of the
// modulus.
//
// Ports:
//    clk        rising-edge clock
//    reset      synchronous, active-high reset
//    X          Montgomery-domain input value (any value below 2^WIDTH)
//    N          modulus, must be odd (even N gives an undefined result, but
//               the block never hangs)
//    beg        level control: 0 = load/abort, 1 = run
//    out        result register, X * 2^(-WIDTH) mod N
//    out_ready  one-cycle pulse on the cycle out takes a new result
//    state      FSM state (0 IDLE, 1 REDUCE, 2 FINAL, 3 DONE)
//
// Handshake: beg is a level, not a pulse. While beg=0 the block sits in IDLE
// and re-latches X/N on every edge. The first edge that samples beg=1 latches
// the operands and starts the run. out_ready pulses for one cycle
// WIDTH+1 edges later. Dropping beg at any point aborts the run or re-arms
// the block. A new run needs at least one edge with beg=0. out holds its last
// result until the next completed run or reset.
//-----------------------------------------------------------------------------
module post_processing #(
   parameter int WIDTH = 256,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] N,
   input  logic             beg,
   output logic [WIDTH-1:0] out,
   output logic             out_ready,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      FINAL  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Counter value on the last reduction iteration.
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [WIDTH:0]   acc;      // accumulator A, one guard bit wide
   logic [WIDTH-1:0] nn;       // modulus latched at start
   logic [CNT_W-1:0] cnt;      // reduction iteration counter

   logic [WIDTH:0]   acc_sum;
   logic [WIDTH:0]   acc_half;
   logic             acc_ge;
   logic [WIDTH-1:0] acc_sub;

   // Datapath for one reduction step and the final correction.
   // A stays below 2^WIDTH, so A+NN fits in WIDTH+1 bits and the halved
   // value falls back below 2^WIDTH. At the end A <= NN, so a single
   // subtract is enough. The compare is WIDTH+1 bits wide, and A == NN
   // reduces to 0.
   always_comb begin
      acc_sum  = acc + {1'b0, nn};
      acc_half = acc[0] ? (acc_sum >> 1) : (acc >> 1);
      acc_ge   = (acc >= {1'b0, nn});
      acc_sub  = acc[WIDTH-1:0] - nn;
   end

   assign state = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         out       <= '0;
         out_ready <= 1'b0;
         acc       <= '0;
         nn        <= '0;
         cnt       <= '0;
      end else begin
         out_ready <= 1'b0;
         if (!beg) begin
            // beg=0 wins in every state: abort or re-arm, and reload operands.
            state_q <= IDLE;
            acc     <= {1'b0, X};
            nn      <= N;
            cnt     <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  // The operands sampled on the start edge are the ones used.
                  acc     <= {1'b0, X};
                  nn      <= N;
                  cnt     <= '0;
                  state_q <= REDUCE;
               end
               REDUCE: begin
                  acc <= acc_half;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST_ITER) begin
                     state_q <= FINAL;
                  end
               end
               FINAL: begin
                  out       <= acc_ge ? acc_sub : acc[WIDTH-1:0];
                  out_ready <= 1'b1;
                  state_q   <= DONE;
               end
               DONE: begin
                  // Hold the result. Only a beg=0 cycle leaves this state.
                  state_q <= DONE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_post_processing.sv
//-----------------------------------------------------------------------------
// tb_post_processing
//
// Directed bench for post_processing. It drives two instances: WIDTH=8 for
// the cycle-by-cycle state sequence, and WIDTH=256 for results, latency,
// abort, reset and boundary cases. Expected results are hand-derived
// constants. The one exception is the near-2^256 modulus case, whose
// expected result comes from an independent modular-multiply reference.
//-----------------------------------------------------------------------------
module tb_post_processing;

   localparam int W  = 256;
   localparam int W8 = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [W-1:0]  x, n, out;
   logic          beg, out_ready;
   logic [1:0]    state;

   logic [W8-1:0] x8, n8, out8;
   logic          beg8, out_ready8;
   logic [1:0]    state8;

   post_processing #(.WIDTH(W), .CNT_W(9)) dut (
      .clk       (clk),
      .reset     (reset),
      .X         (x),
      .N         (n),
      .beg       (beg),
      .out       (out),
      .out_ready (out_ready),
      .state     (state)
   );

   post_processing #(.WIDTH(W8), .CNT_W(4)) dut8 (
      .clk       (clk),
      .reset     (reset),
      .X         (x8),
      .N         (n8),
      .beg       (beg8),
      .out       (out8),
      .out_ready (out_ready8),
      .state     (state8)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, want);
   endtask

   // ---------------- reference (independent modular arithmetic) ----------------
   function automatic logic [W-1:0] mod_n(input logic [W-1:0] v, input logic [W-1:0] m);
      logic [W:0] r;
      r = '0;
      for (int i = W - 1; i >= 0; i--) begin
         r = {r[W-1:0], v[i]};
         if (r >= {1'b0, m}) r = r - {1'b0, m};
      end
      return r[W-1:0];
   endfunction

   // a*b mod m by MSB-first double-and-add; a, b < m
   function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
      logic [W+1:0] acc;
      acc = '0;
      for (int i = W - 1; i >= 0; i--) begin
         acc = acc << 1;
         if (acc >= {2'b0, m}) acc = acc - {2'b0, m};
         if (b[i]) begin
            acc = acc + {2'b0, a};
            if (acc >= {2'b0, m}) acc = acc - {2'b0, m};
         end
      end
      return acc[W-1:0];
   endfunction

   // x * (2^-1)^W mod m, with 2^-1 = (m+1)/2 for odd m
   function automatic logic [W-1:0] mont_ref(input logic [W-1:0] xv, input logic [W-1:0] m);
      logic [W:0]   m1;
      logic [W-1:0] half, p;
      m1   = {1'b0, m} + 1'b1;
      half = m1[W:1];
      p    = W'(1);
      for (int i = 0; i < W; i++) p = mod_mul(p, half, m);
      return mod_mul(mod_n(xv, m), p, m);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One beg=0 edge, then the start edge. Inputs are scrambled afterwards;
   // the DUT must ignore them.
   task automatic launch(input logic [W-1:0] xv, input logic [W-1:0] nv);
      beg = 1'b0; x = xv; n = nv;
      tick();
      beg = 1'b1;
      tick();
      check("start state", W'(state), W'(1));
      x = ~xv;
      n = ~nv;
   endtask

   task automatic wait_result(input string tag);
      int lat;
      logic [W-1:0] want;
      lat = -1;
      for (int k = 1; k <= W + 20; k++) begin
         tick();
         if (out_ready) begin
            lat = k;
            break;
         end
      end
      check({tag, " latency"}, W'(lat), W'(W + 1));
      want = exp_q.pop_front();
      check({tag, " out"}, out, want);
      check({tag, " done state"}, W'(state), W'(3));
      tick();
      check({tag, " ready drop"}, W'(out_ready), W'(0));
      check({tag, " out hold"}, out, want);
   endtask

   task automatic run(input string tag, input logic [W-1:0] xv, input logic [W-1:0] nv,
                      input logic [W-1:0] want);
      exp_q.push_back(want);
      launch(xv, nv);
      wait_result(tag);
   endtask

   // WIDTH=8 run with per-edge state / out_ready check after the start edge
   task automatic run8(input logic [W8-1:0] xv, input logic [W8-1:0] nv, input logic [W8-1:0] ev);
      logic [1:0] exp_state;
      beg8 = 1'b0; x8 = xv; n8 = nv;
      tick();
      beg8 = 1'b1;
      tick();
      x8 = ~xv;
      n8 = ~nv;
      for (int j = 0; j <= 10; j++) begin
         if (j > 0) tick();
         exp_state = (j <= 7) ? 2'd1 : ((j == 8) ? 2'd2 : 2'd3);
         check($sformatf("w8 x=%0d state e%0d", xv, j), W'(state8), W'(exp_state));
         check($sformatf("w8 x=%0d ready e%0d", xv, j), W'(out_ready8), W'(j == 9));
         if (j >= 9) check($sformatf("w8 x=%0d out e%0d", xv, j), W'(out8), W'(ev));
      end
      beg8 = 1'b0;
      tick();
      check("w8 back to idle", W'(state8), W'(0));
   endtask

   // ---------------- main sequence ----------------
   logic [W-1:0] big_n, pow255, xmax, nmax, ref_max, prev_out;
   int early;

   initial begin
      reset = 1'b1;
      beg = 1'b0; x = '0; n = '0;
      beg8 = 1'b0; x8 = '0; n8 = '0;
      big_n  = (W'(1) << 255) + W'(1);
      pow255 = W'(1) << 255;
      xmax   = '1;
      nmax   = ~W'(188);
      ref_max = mont_ref(xmax, nmax);

      repeat (3) tick();
      check("reset state", W'(state), W'(0));
      check("reset out", out, W'(0));
      check("reset ready", W'(out_ready), W'(0));
      check("reset state w8", W'(state8), W'(0));
      check("reset out w8", W'(out8), W'(0));
      reset = 1'b0;
      tick();

      // WIDTH=8, 2^8 = 9 (mod 13), 2^-8 = 3 (mod 13); 2^8 = 1 (mod 255)
      run8(8'd1,   8'd13,  8'd3);
      run8(8'd12,  8'd13,  8'd10);
      run8(8'd255, 8'd13,  8'd11);
      run8(8'd254, 8'd255, 8'd254);

      // WIDTH=256, N=13: 2^256 = 3 (mod 13), inverse 9
      run("n13 x1", W'(1), W'(13), W'(9));
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold ready", W'(out_ready), W'(0));
      end
      check("hold state", W'(state), W'(3));
      check("hold out", out, W'(9));

      // N = 2^255+1: 2^256 = -2, so pre(5) = N-10 = 2^255-9, pre(N-1) = 2
      run("rt m5",   pow255 - W'(9), big_n, W'(5));
      run("rt mN-1", W'(2),          big_n, big_n - W'(1));

      // boundaries
      run("x zero",  W'(0),  W'(13), W'(0));
      run("x eq n",  W'(13), W'(13), W'(0));
      run("x eq bn", big_n,  big_n,  W'(0));
      run("x max",   xmax,   nmax,   ref_max);

      // abort at iteration 100
      prev_out = out;
      launch(W'(1), W'(13));
      early = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (out_ready) early++;
      end
      check("abort pre state", W'(state), W'(1));
      beg = 1'b0;
      tick();
      check("abort state", W'(state), W'(0));
      check("abort ready", W'(out_ready), W'(0));
      check("abort early ready", W'(early), W'(0));
      check("abort out kept", out, prev_out);
      run("after abort", pow255 - W'(9), big_n, W'(5));

      // reset during REDUCE
      launch(W'(3), W'(13));
      repeat (50) tick();
      reset = 1'b1;
      tick();
      check("mid reset state", W'(state), W'(0));
      check("mid reset out", out, W'(0));
      check("mid reset ready", W'(out_ready), W'(0));
      reset = 1'b0;
      run("after reset", W'(2), big_n, pow255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
